uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, packet-locked sharing of one uart_tx among NUM_REQ
//            byte-stream requesters. Optional stale-lock timeout enabled by
//            defining UART_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = `UART_DATA_WIDTH,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    input  logic                          uart_tx_ready,
    output logic                          uart_tx_valid,
    output logic [DATA_WIDTH-1:0]         uart_tx_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TIMEOUT < 1) begin : g_bad_param
            $error("uart_tx_arbiter: NUM_REQ must be 2..8 and LOCK_TIMEOUT >= 1");
        end
    endgenerate

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_lock;
    logic [IDX_W-1:0]        r_lock_id;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [NUM_REQ-1:0]      r_grant;
    logic [DATA_WIDTH-1:0]   r_tx_data;

    logic [IDX_W-1:0]        w_sel;
    logic [IDX_W-1:0]        w_cand;
    logic                    w_sel_valid;
    logic                    w_accept;
    logic [NUM_REQ-1:0]      w_sel_onehot;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_to_fire;

    // Locked: only the owner may continue. Unlocked: scan from rr_ptr+1 upward.
    always_comb begin
        w_sel       = '0;
        w_cand      = '0;
        w_sel_valid = 1'b0;
        if (r_lock) begin
            w_sel       = r_lock_id;
            w_sel_valid = req_valid[r_lock_id];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                if (!w_sel_valid && req_valid[w_cand]) begin
                    w_sel       = w_cand;
                    w_sel_valid = 1'b1;
                end
            end
        end
    end

    // Gated by rst so no byte is handed over while the arbiter is held in reset.
    assign w_accept     = !rst && (r_state == S_IDLE) && w_sel_valid && uart_tx_ready;
    assign w_sel_onehot = NUM_REQ'(1) << w_sel;
    assign w_sel_data   = req_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_run;

    assign w_to_run  = (r_state == S_IDLE) && r_lock && !req_valid[r_lock_id];
    assign w_to_fire = w_to_run && (r_to_cnt == TO_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_accept || !r_lock || w_to_fire) begin
            r_to_cnt <= '0;
        end else if (w_to_run) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_to_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // uart_tx_ready drops once the frame starts and rises when it ends.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (w_accept)       w_state_nxt = S_ISSUE;
            S_ISSUE:      if (uart_tx_ready)  w_state_nxt = S_WAIT_START;
            S_WAIT_START: if (!uart_tx_ready) w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE:  if (uart_tx_ready)  w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_rr_ptr  <= IDX_W'(NUM_REQ - 1);
            r_grant   <= '0;
            r_tx_data <= '0;
        end else if (w_accept) begin
            r_tx_data <= w_sel_data;
            r_grant   <= w_sel_onehot;
            if (req_last[w_sel]) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= w_sel;
            end else begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end
        end else if (w_to_fire) begin
            r_lock   <= 1'b0;
            r_rr_ptr <= r_lock_id;
            r_grant  <= '0;
        end else if (r_state == S_WAIT_DONE && uart_tx_ready && !r_lock) begin
            r_grant <= '0;
        end
    end

    assign req_ready     = w_accept ? w_sel_onehot : '0;
    assign grant         = r_grant;
    assign busy          = (r_state != S_IDLE) || r_lock;
    assign uart_tx_valid = (r_state == S_ISSUE);
    assign uart_tx_data  = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int FRAME = 40;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] g;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        busy;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_hold = 1'b0;
    int          tx_cnt;

    exp_t        exp_q[$];
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [1:0]  acc;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (2),
        .DATA_WIDTH   (8),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .grant         (grant),
        .busy          (busy),
        .uart_tx_ready (tx_ready),
        .uart_tx_valid (tx_valid),
        .uart_tx_data  (tx_data)
    );

    // Behavioural transmitter: ready only while idle, busy for one frame.
    always @(posedge clk or posedge rst) begin
        if (rst)                       tx_cnt <= 0;
        else if (tx_valid && tx_ready) tx_cnt <= FRAME;
        else if (tx_cnt != 0)          tx_cnt <= tx_cnt - 1;
    end
    assign tx_ready = (tx_cnt == 0) && !tx_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Requester driver: present queue heads on negedge, note acceptance mid-low-phase.
    initial begin
        logic [8:0] h;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        acc       = '0;
        forever begin
            @(negedge clk);
            if (acc[0] && q0.size() > 0) void'(q0.pop_front());
            if (acc[1] && q1.size() > 0) void'(q1.pop_front());
            acc = '0;
            if (q0.size() > 0) begin
                h = q0[0];
                req_valid[0] = 1'b1; req_data[7:0] = h[7:0]; req_last[0] = h[8];
            end else begin
                req_valid[0] = 1'b0; req_data[7:0] = '0; req_last[0] = 1'b0;
            end
            if (q1.size() > 0) begin
                h = q1[0];
                req_valid[1] = 1'b1; req_data[15:8] = h[7:0]; req_last[1] = h[8];
            end else begin
                req_valid[1] = 1'b0; req_data[15:8] = '0; req_last[1] = 1'b0;
            end
            #1;
            if (!rst) begin
                acc = req_ready;
                if (req_ready != 2'b00) begin
                    check("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
                    check("ready_to_idle_req", {30'd0, req_ready & ~req_valid}, 32'd0);
                end
            end
        end
    end

    // Monitor: every transmitter handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", {24'd0, tx_data}, {24'd0, e.d});
                check("tx_grant", {30'd0, grant}, {30'd0, e.g});
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic [1:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        acc = '0;
    endtask

    task automatic do_reset(input logic hold);
        @(posedge clk);
        #3;
        tx_hold = hold;
        assert_reset();
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain actual=%0d_left required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({name, "_grant_clear"}, {30'd0, grant}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Single byte: 1-cycle accept pulse, valid one cycle later for one cycle.
        do_reset(1'b0);
        q0.push_back({1'b1, 8'h55});
        push_exp(8'h55, 2'b01);
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (req_ready != 2'b01 && n < 20);
        check("single_accept", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        #2;
        check("single_ready_pulse", {30'd0, req_ready}, 32'd0);
        check("single_valid", {31'd0, tx_valid}, 32'd1);
        check("single_data", {24'd0, tx_data}, 32'h55);
        @(negedge clk);
        #2;
        check("single_valid_drop", {31'd0, tx_valid}, 32'd0);
        wait_drain("single", 100);
        wait_idle("single", 100);

        // Round-robin between two always-valid requesters.
        do_reset(1'b0);
        q0.push_back({1'b1, 8'hA0}); q0.push_back({1'b1, 8'hA1});
        q1.push_back({1'b1, 8'hB0}); q1.push_back({1'b1, 8'hB1});
        push_exp(8'hA0, 2'b01); push_exp(8'hB0, 2'b10);
        push_exp(8'hA1, 2'b01); push_exp(8'hB1, 2'b10);
        wait_drain("rr", 400);
        wait_idle("rr", 100);

        // Packet lock: req1 waits behind req0's three-byte packet.
        do_reset(1'b0);
        q1.push_back({1'b1, 8'hAA});
        q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02}); q0.push_back({1'b1, 8'h03});
        push_exp(8'h01, 2'b01); push_exp(8'h02, 2'b01);
        push_exp(8'h03, 2'b01); push_exp(8'hAA, 2'b10);
        while (exp_q.size() > 2) @(posedge clk);
        repeat (FRAME / 2) @(posedge clk);
        #1;
        check("lock_grant_mid_packet", {30'd0, grant}, 32'd1);
        check("lock_busy_mid_packet", {31'd0, busy}, 32'd1);
        wait_drain("lock", 400);
        wait_idle("lock", 100);

        // Transmitter held not-ready after reset.
        do_reset(1'b1);
        q0.push_back({1'b1, 8'h5A});
        push_exp(8'h5A, 2'b01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check("notready_req_ready", {30'd0, req_ready}, 32'd0);
            check("notready_tx_valid", {31'd0, tx_valid}, 32'd0);
        end
        @(posedge clk);
        #3;
        tx_hold = 1'b0;
        wait_drain("notready", 100);
        wait_idle("notready", 100);

        // Asynchronous reset in WAIT_DONE, then req0 served first.
        do_reset(1'b0);
        q0.push_back({1'b1, 8'h77});
        push_exp(8'h77, 2'b01);
        wait_drain("midframe", 100);
        repeat (4) @(posedge clk);
        #1;
        check("midframe_busy_before", {31'd0, busy}, 32'd1);
        #2;
        assert_reset();
        #1;
        check("midframe_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("midframe_rst_grant", {30'd0, grant}, 32'd0);
        check("midframe_rst_busy", {31'd0, busy}, 32'd0);
        q0.push_back({1'b1, 8'hC0});
        q1.push_back({1'b1, 8'hD0});
        push_exp(8'hC0, 2'b01);
        push_exp(8'hD0, 2'b10);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        wait_drain("after_rst", 400);
        wait_idle("after_rst", 100);

        // Stale lock: req0 opens a packet and goes quiet while req1 waits.
        do_reset(1'b0);
        q0.push_back({1'b0, 8'h10});
        q1.push_back({1'b1, 8'hBB});
        push_exp(8'h10, 2'b01);
`ifdef UART_ARB_TIMEOUT_EN
        push_exp(8'hBB, 2'b10);
        wait_drain("timeout", 400);
        wait_idle("timeout", 100);
`else
        wait_drain("nolock_drop", 100);
        repeat (200) @(posedge clk);
        #1;
        check("lock_held_grant", {30'd0, grant}, 32'd1);
        check("lock_held_busy", {31'd0, busy}, 32'd1);
        check("lock_held_bb_pending", q1.size(), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
